icache: RTL and testbench

- Read-only, direct-mapped instruction cache; the responder for the fetch stage's instruction-read interface.
- Accepts the fetch stage's `inst_read`/`inst_addr` and returns `inst_rdata` with an `inst_resp` strobe.
- On a miss, fills a 256-bit line from physical memory over a `pmem_read`/`pmem_resp` handshake.
- Sits between the IF stage and the memory arbiter; the fetch requester holds `inst_addr` stable while `inst_resp` is low.

---
 rtl/icache.sv | 149 ++++++++++++++
 tb/tb_icache.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache with 0-cycle hits and a
// two-state (IDLE/FILL) line-fill engine toward physical memory.
module icache #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inst_read,
    input  logic [31:0]  inst_addr,
    output logic [31:0]  inst_rdata,
    output logic         inst_resp,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 32 - S_OFFSET - S_INDEX;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic logic [31:0] select_word(input logic [255:0] line, input logic [2:0] word);
        return line[{word, 5'd0} +: 32];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    state_t               state_r;
    logic [SETS-1:0]      valid_r;
    logic [TAG_W-1:0]     tag_r  [SETS];
    logic [255:0]         data_r [SETS];
    logic [TAG_W-1:0]     lat_tag_r;
    logic [S_INDEX-1:0]   lat_idx_r;
    logic [31:0]          hit_count_r;
    logic [31:0]          miss_count_r;

    logic [TAG_W-1:0]     tag_s;
    logic [S_INDEX-1:0]   idx_s;
    logic [2:0]           word_s;
    logic                 hit_s;
    logic                 miss_s;
    logic                 unused_s;

    assign tag_s    = inst_addr[31:S_OFFSET+S_INDEX];
    assign idx_s    = inst_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign word_s   = inst_addr[4:2];
    assign unused_s = ^inst_addr[1:0];

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

    // Lookup and response; a reset cycle never responds.
    always_comb begin
        hit_s        = 1'b0;
        miss_s       = 1'b0;
        inst_resp    = 1'b0;
        inst_rdata   = 32'h0;
        pmem_read    = 1'b0;
        pmem_address = 32'h0;
        case (state_r)
            IDLE: begin
                if (inst_read && !reset) begin
                    if (valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
                        hit_s = 1'b1;
                    end else begin
                        miss_s = 1'b1;
                    end
                end else begin
                    hit_s = 1'b0;
                end
                inst_resp = hit_s;
                if (hit_s) begin
                    inst_rdata = select_word(data_r[idx_s], word_s);
                end else begin
                    inst_rdata = 32'h0;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {lat_tag_r, lat_idx_r, {S_OFFSET{1'b0}}};
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

    // Controller state, valid bits and the latched miss address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            valid_r   <= '0;
            lat_tag_r <= '0;
            lat_idx_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_s) begin
                        lat_tag_r <= tag_s;
                        lat_idx_r <= idx_s;
                        state_r   <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_r[lat_idx_r] <= 1'b1;
                        state_r            <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Line storage is not reset; a fill interrupted by reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == FILL) && pmem_resp) begin
            tag_r[lat_idx_r]  <= lat_tag_r;
            data_r[lat_idx_r] <= pmem_rdata;
        end
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_r  <= 32'h0;
            miss_count_r <= 32'h0;
        end else begin
            if (hit_s) begin
                hit_count_r <= sat_inc(hit_count_r);
            end
            if (miss_s) begin
                miss_count_r <= sat_inc(miss_count_r);
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// compared against a set-indexed behavioural model of the cache contents.
module tb_icache;

    logic         clk = 1'b0;
    logic         reset;
    logic         inst_read;
    logic [31:0]  inst_addr;
    logic [31:0]  inst_rdata;
    logic         inst_resp;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks = 0;
    int errors = 0;

    // Reference model: per-set contents and expected counter values
    bit           m_valid [8];
    logic [31:0]  m_tag   [8];
    logic [31:0]  m_data  [8][8];
    logic [31:0]  m_hits;
    logic [31:0]  m_miss;

    icache dut (
        .clk(clk), .reset(reset), .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_resp(inst_resp), .pmem_read(pmem_read),
        .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] line;
        for (int k = 0; k < 8; k++) line[k*32 +: 32] = base + 32'(k);
        return line;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
        m_hits = 32'd0;
        m_miss = 32'd0;
    endtask

    task automatic model_fill(input logic [31:0] addr, input logic [31:0] base);
        int s;
        s = int'((addr >> 5) % 32'd8);
        m_valid[s] = 1'b1;
        m_tag[s]   = addr >> 8;
        for (int k = 0; k < 8; k++) m_data[s][k] = base + 32'(k);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch; on a miss the bench memory answers after lat FILL cycles.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] base, input int lat);
        int s;
        logic [31:0] t;
        logic [31:0] w;
        logic [31:0] la;
        s  = int'((addr >> 5) % 32'd8);
        t  = addr >> 8;
        w  = (addr >> 2) & 32'd7;
        la = addr & 32'hFFFF_FFE0;
        inst_read = 1'b1;
        inst_addr = addr;
        #1;
        if (m_valid[s] && m_tag[s] == t) begin
            checks++;
            if (inst_resp !== 1'b1 || inst_rdata !== m_data[s][w]) begin
                errors++;
                $display("FAIL hit_resp addr=%h got resp=%b data=%h want resp=1 data=%h",
                         addr, inst_resp, inst_rdata, m_data[s][w]);
            end
            checks++;
            if (pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL hit_no_pmem addr=%h got pmem_read=%b want 0", addr, pmem_read);
            end
            m_hits = m_hits + 32'd1;
            next_cycle();
        end else begin
            checks++;
            if (inst_resp !== 1'b0) begin
                errors++;
                $display("FAIL miss_resp addr=%h got resp=%b want 0", addr, inst_resp);
            end
            m_miss = m_miss + 32'd1;
            next_cycle();
            for (int i = 1; i <= lat; i++) begin
                if (i == lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = make_line(base);
                end
                checks++;
                if (pmem_read !== 1'b1 || pmem_address !== la || inst_resp !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_req addr=%h got rd=%b pa=%h resp=%b want rd=1 pa=%h resp=0",
                             addr, pmem_read, pmem_address, inst_resp, la);
                end
                next_cycle();
            end
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            model_fill(addr, base);
            #1;
            checks++;
            if (inst_resp !== 1'b1 || inst_rdata !== m_data[s][w] || pmem_read !== 1'b0) begin
                errors++;
                $display("FAIL miss_return addr=%h got resp=%b data=%h rd=%b want resp=1 data=%h rd=0",
                         addr, inst_resp, inst_rdata, pmem_read, m_data[s][w]);
            end
            m_hits = m_hits + 32'd1;
            next_cycle();
        end
        inst_read = 1'b0;
        checks++;
        if (hit_count !== m_hits || miss_count !== m_miss) begin
            errors++;
            $display("FAIL counters addr=%h got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     addr, hit_count, miss_count, m_hits, m_miss);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        inst_read  = 1'b0;
        inst_addr  = 32'h0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (inst_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0 ||
            hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got resp=%b rd=%b pa=%h hit=%0d miss=%0d want all 0",
                     inst_resp, pmem_read, pmem_address, hit_count, miss_count);
        end
        next_cycle();
    endtask

    task automatic test_miss_then_hit();
        fetch(32'h0000_0060, 32'h0000_1000, 4);
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL first_miss_counts got hit=%0d miss=%0d want 1 1", hit_count, miss_count);
        end
        inst_read = 1'b1;
        inst_addr = 32'h0000_006C;
        #1;
        checks++;
        if (inst_resp !== 1'b1 || inst_rdata !== 32'h0000_1003 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL same_line_hit got resp=%b data=%h rd=%b want 1 00001003 0",
                     inst_resp, inst_rdata, pmem_read);
        end
        m_hits = m_hits + 32'd1;
        next_cycle();
        inst_read = 1'b0;
        checks++;
        if (hit_count !== 32'd2) begin
            errors++;
            $display("FAIL hit_count_two got %0d want 2", hit_count);
        end
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0160, 32'h0000_2000, 3);
        fetch(32'h0000_0060, 32'h0000_1000, 2);
        checks++;
        if (miss_count !== 32'd3) begin
            errors++;
            $display("FAIL conflict_miss_count got %0d want 3", miss_count);
        end
    endtask

    task automatic test_drop_during_fill();
        inst_read = 1'b1;
        inst_addr = 32'h0000_1234;
        #1;
        checks++;
        if (inst_resp !== 1'b0) begin
            errors++;
            $display("FAIL drop_first_resp got %b want 0", inst_resp);
        end
        m_miss = m_miss + 32'd1;
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                inst_read = 1'b0;
                inst_addr = $urandom;
            end
            if (c == 3) begin
                pmem_resp  = 1'b1;
                pmem_rdata = make_line(32'h0000_3000);
            end
            checks++;
            if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_1220 || inst_resp !== 1'b0) begin
                errors++;
                $display("FAIL drop_fill_addr cycle=%0d got rd=%b pa=%h resp=%b want 1 00001220 0",
                         c, pmem_read, pmem_address, inst_resp);
            end
            next_cycle();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        model_fill(32'h0000_1234, 32'h0000_3000);
        #1;
        checks++;
        if (inst_resp !== 1'b0 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_resp got resp=%b rd=%b want 0 0", inst_resp, pmem_read);
        end
        next_cycle();
        inst_read = 1'b1;
        inst_addr = 32'h0000_1234;
        #1;
        checks++;
        if (inst_resp !== 1'b1 || inst_rdata !== 32'h0000_3005) begin
            errors++;
            $display("FAIL drop_later_hit got resp=%b data=%h want 1 00003005", inst_resp, inst_rdata);
        end
        m_hits = m_hits + 32'd1;
        next_cycle();
        inst_read = 1'b0;
    endtask

    task automatic test_reset_in_fill();
        inst_read = 1'b1;
        inst_addr = 32'h0000_0400;
        m_miss = m_miss + 32'd1;
        next_cycle();
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0400) begin
            errors++;
            $display("FAIL rif_fill_start got rd=%b pa=%h want 1 00000400", pmem_read, pmem_address);
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset     = 1'b0;
        inst_read = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pmem_read !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL rif_after_reset got rd=%b hit=%0d miss=%0d want 0 0 0",
                     pmem_read, hit_count, miss_count);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = make_line(32'h0000_5000);
        next_cycle();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL rif_late_resp got rd=%b hit=%0d miss=%0d want 0 0 0",
                     pmem_read, hit_count, miss_count);
        end
        next_cycle();
        fetch(32'h0000_0060, 32'h0000_1000, 2);
        fetch(32'h0000_0400, 32'h0000_6000, 1);
        // Reset raised alongside a request that would hit
        inst_read = 1'b1;
        inst_addr = 32'h0000_0060;
        reset     = 1'b1;
        #1;
        checks++;
        if (inst_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_read_resp got %b want 0", inst_resp);
        end
        next_cycle();
        reset     = 1'b0;
        inst_read = 1'b0;
        model_reset();
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_with_read_counts got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 80; n++) begin
            addr = ($urandom_range(3, 0) << 8) | ($urandom_range(7, 0) << 5) |
                   ($urandom_range(7, 0) << 2) | $urandom_range(3, 0);
            fetch(addr, $urandom, int'($urandom_range(5, 1)));
            if ($urandom_range(3, 0) == 0) begin
                // Stray memory response while idle must be ignored
                pmem_resp  = 1'b1;
                pmem_rdata = make_line($urandom);
                next_cycle();
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        inst_read  = 1'b0;
        inst_addr  = 32'h0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_drop_during_fill();
        test_reset_in_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
